// File: rtl/bcd_pkg.sv
// Shared digit types and constants for the multi-digit BCD counter.
// Used by bcd_digit and bcd_counter_n.
package bcd_pkg;

  localparam int DW = 4;

  typedef logic [DW-1:0] digit_t;

  localparam digit_t BCD_MAX  = 4'd9;
  localparam digit_t BCD_ZERO = 4'd0;

  function automatic logic is_bcd(input digit_t d);
    return d <= BCD_MAX;
  endfunction

  function automatic digit_t dig_inc(input digit_t d);
    return (d >= BCD_MAX) ? BCD_ZERO : d + 4'd1;
  endfunction

  function automatic digit_t dig_dec(input digit_t d);
    digit_t r;
    if (d == BCD_ZERO)
      r = BCD_MAX;
    else if (d > BCD_MAX)
      r = BCD_MAX;
    else
      r = d - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear/load/step register with terminal flags.
// Step enable comes from the carry/borrow chain in the parent.
import bcd_pkg::*;

module bcd_digit (
  input  logic   clk,
  input  logic   reset,
  input  logic   step_i,
  input  logic   up_i,
  input  logic   clr_i,
  input  logic   load_i,
  input  digit_t load_digit_i,
  output digit_t digit_o,
  output logic   at_max_o,
  output logic   at_zero_o
);

  digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    priority case (1'b1)
      clr_i:  digit_d = BCD_ZERO;
      load_i: digit_d = load_digit_i;
      step_i: digit_d = up_i ? dig_inc(digit_q)
                             : dig_dec(digit_q);
      default: digit_d = digit_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      digit_q <= BCD_ZERO;
    else
      digit_q <= digit_d;
  end

  // Out-of-range digits count as terminal so the carry
  // propagates together with their self-correcting step to 0.
  assign at_max_o  = digit_q >= BCD_MAX;
  assign at_zero_o = digit_q == BCD_ZERO;
  assign digit_o   = digit_q;

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised N-digit BCD up/down counter with clear, load and tc.
// BCD_LOAD_CHECK_EN: zero non-BCD load digits and pulse err.
import bcd_pkg::*;

module bcd_counter_n #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  wrap,
  output logic                  err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   lo_max;
  logic [DIGITS:0]   lo_zero;
  logic [4*DIGITS-1:0] ld_val;
  logic wrap_q, wrap_d;

  assign lo_max[0]  = 1'b1;
  assign lo_zero[0] = 1'b1;

`ifdef BCD_LOAD_CHECK_EN
  logic [DIGITS-1:0] bad;
  logic err_q, err_d;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign lo_max[i+1]  = lo_max[i] & at_max[i];
    assign lo_zero[i+1] = lo_zero[i] & at_zero[i];
    assign step[i] = x & (up ? lo_max[i] : lo_zero[i]);

`ifdef BCD_LOAD_CHECK_EN
    assign bad[i] = ~is_bcd(load_val[4*i +: 4]);
    assign ld_val[4*i +: 4] = bad[i] ? BCD_ZERO
                                     : load_val[4*i +: 4];
`else
    assign ld_val[4*i +: 4] = load_val[4*i +: 4];
`endif

    bcd_digit u_dig (
      .clk          (clk),
      .reset        (reset),
      .step_i       (step[i]),
      .up_i         (up),
      .clr_i        (clr),
      .load_i       (load),
      .load_digit_i (ld_val[4*i +: 4]),
      .digit_o      (bcd_out[4*i +: 4]),
      .at_max_o     (at_max[i]),
      .at_zero_o    (at_zero[i])
    );
  end

  // Whole-vector terminal is the top of the prefix chains.
  assign tc = x & (up ? lo_max[DIGITS] : lo_zero[DIGITS]);

  assign wrap_d = tc & ~clr & ~load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wrap_q <= 1'b0;
    else
      wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

`ifdef BCD_LOAD_CHECK_EN
  assign err_d = load & ~clr & (|bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n (4-digit) and a 2x2-digit cascade.
// Expectations are cycle-stamped; a negedge monitor pops and compares.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 0, up = 1, clr = 0, load = 0;
  logic [15:0] load_val = '0;
  logic [15:0] bcd_out;
  logic tc, wrap, err;

  logic cas_x = 0, cas_clr = 0;
  logic [7:0] bcd_a, bcd_b;
  logic tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;
  logic [15:0] cas_val;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    int          cyc;
    bit          src;
    logic [15:0] bcd;
    logic        tc;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bcd_counter_n #(.DIGITS(4)) dut (
    .clk(clk), .reset(rst_n), .x(x), .up(up),
    .clr(clr), .load(load), .load_val(load_val),
    .bcd_out(bcd_out), .tc(tc), .wrap(wrap), .err(err)
  );

  bcd_counter_n #(.DIGITS(2)) cas_lo (
    .clk(clk), .reset(rst_n), .x(cas_x), .up(1'b1),
    .clr(cas_clr), .load(1'b0), .load_val(8'h00),
    .bcd_out(bcd_a), .tc(tc_a), .wrap(wrap_a), .err(err_a)
  );

  bcd_counter_n #(.DIGITS(2)) cas_hi (
    .clk(clk), .reset(rst_n), .x(tc_a), .up(1'b1),
    .clr(cas_clr), .load(1'b0), .load_val(8'h00),
    .bcd_out(bcd_b), .tc(tc_b), .wrap(wrap_b), .err(err_b)
  );

  assign cas_val = {bcd_b, bcd_a};

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  function automatic void expm(input string tag, input logic [15:0] b,
                               input logic t, input logic w,
                               input logic er);
    exp_t r;
    r.tag = tag; r.cyc = cyc; r.src = 1'b0;
    r.bcd = b; r.tc = t; r.wrap = w; r.err = er;
    sb.push_back(r);
  endfunction

  function automatic void expc(input string tag, input logic [15:0] b);
    exp_t r;
    r.tag = tag; r.cyc = cyc; r.src = 1'b1;
    r.bcd = b; r.tc = 1'b0; r.wrap = 1'b0; r.err = 1'b0;
    sb.push_back(r);
  endfunction

  task automatic drv(input logic xi, input logic ui, input logic ci,
                     input logic li, input logic [15:0] lv);
    @(posedge clk);
    #1;
    x = xi; up = ui; clr = ci; load = li; load_val = lv;
  endtask

  task automatic cdrv(input logic xi, input logic ci);
    @(posedge clk);
    #1;
    cas_x = xi; cas_clr = ci;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.cyc < cyc) begin
        failed++;
        $display("FAIL %s: slot %0d missed at cycle %0d", e.tag, e.cyc, cyc);
      end else if (e.src) begin
        if (cas_val !== e.bcd) begin
          failed++;
          $display("FAIL %s: got %h expected %h", e.tag, cas_val, e.bcd);
        end
      end else if ({bcd_out, tc, wrap, err} !==
                   {e.bcd, e.tc, e.wrap, e.err}) begin
        failed++;
        $display("FAIL %s: got bcd=%h tc=%b wrap=%b err=%b expected bcd=%h tc=%b wrap=%b err=%b",
                 e.tag, bcd_out, tc, wrap, err, e.bcd, e.tc, e.wrap, e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst_n = 1'b1;

    drv(0, 1, 0, 0, 16'h0000);
    expm("reset", 16'h0000, 0, 0, 0);
    drv(0, 1, 0, 1, 16'h0123);
    drv(0, 1, 0, 0, 16'h0000);
    expm("load0123", 16'h0123, 0, 0, 0);

    drv(1, 1, 0, 0, 16'h0000);
    #1;
    rst_n = 1'b0;
    x = 0;
    expm("rst_async", 16'h0000, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) drv(1, 1, 0, 0, 16'h0000);
    drv(0, 1, 0, 0, 16'h0000);
    expm("after_rst", 16'h0005, 0, 0, 0);

    drv(0, 1, 0, 1, 16'h9998);
    drv(1, 1, 0, 0, 16'h0000);
    expm("up_9998", 16'h9998, 0, 0, 0);
    drv(1, 1, 0, 0, 16'h0000);
    expm("tc_up", 16'h9999, 1, 0, 0);
    drv(0, 1, 0, 0, 16'h0000);
    expm("wrap_up", 16'h0000, 0, 1, 0);
    drv(0, 1, 0, 0, 16'h0000);
    expm("wrap_once", 16'h0000, 0, 0, 0);

    drv(0, 0, 0, 1, 16'h1000);
    drv(1, 0, 0, 0, 16'h0000);
    expm("dn_1000", 16'h1000, 0, 0, 0);
    drv(0, 0, 0, 0, 16'h0000);
    expm("borrow", 16'h0999, 0, 0, 0);
    drv(0, 0, 0, 1, 16'h0000);
    drv(1, 0, 0, 0, 16'h0000);
    expm("tc_dn", 16'h0000, 1, 0, 0);
    drv(0, 0, 0, 0, 16'h0000);
    expm("wrap_dn", 16'h9999, 0, 1, 0);

    drv(1, 0, 0, 1, 16'h9999);
    expm("dir_dn", 16'h9999, 0, 0, 0);
    drv(1, 1, 1, 1, 16'h4321);
    expm("tc_clr", 16'h9999, 1, 0, 0);
    drv(1, 1, 0, 1, 16'h4321);
    expm("clr_win", 16'h0000, 0, 0, 0);
    drv(0, 1, 0, 0, 16'h0000);
    expm("load_win", 16'h4321, 0, 0, 0);

    drv(0, 1, 0, 1, 16'h00A7);
    drv(0, 1, 0, 0, 16'h0000);
`ifdef BCD_LOAD_CHECK_EN
    expm("bad_load", 16'h0007, 0, 0, 1);
    drv(0, 1, 1, 1, 16'h00A7);
    expm("err_once", 16'h0007, 0, 0, 0);
    drv(0, 1, 0, 0, 16'h0000);
    expm("clr_err", 16'h0000, 0, 0, 0);
`else
    expm("bad_load", 16'h00A7, 0, 0, 0);
    repeat (3) drv(1, 1, 0, 0, 16'h0000);
    drv(0, 1, 0, 0, 16'h0000);
    expm("self_fix", 16'h0100, 0, 0, 0);
`endif

    cdrv(0, 1);
    for (int i = 0; i < 10000; i++) begin
      cdrv(1, 0);
      expc("cascade", to_bcd(i));
    end
    cdrv(0, 0);
    expc("cas_wrap", 16'h0000);

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      failed++;
      $display("FAIL %s: never compared (slot %0d)", e.tag, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
